decode_queue: RTL
=================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of decoded-entry slots (power of two, 2..16).
REQ-002 Parameter PC_WIDTH, default 32, width of the carried program counter.
REQ-003 Parameter ILL_CNT_WIDTH, default 16, width of the illegal-instruction counter.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all queued entries (branch redirect).
REQ-007 in_valid  input  1  fetch offers an instruction.
REQ-008 in_ready  output  1  queue can accept this cycle.
REQ-009 in_instr  input  32  raw instruction (instruction_type).
REQ-010 in_pc  input  PC_WIDTH  PC of in_instr.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  execute consumes head this cycle.
REQ-013 out_control  output  control_type  decoded control of head.
REQ-014 out_instr  output  32  raw instruction of head.
REQ-015 out_pc  output  PC_WIDTH  PC of head.
REQ-016 out_illegal  output  1  head failed decode.
REQ-017 illegal_count  output  ILL_CNT_WIDTH  saturating count of accepted illegal instructions.
REQ-018 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-020 in_ready SHALL be (count < DEPTH) && !flush; no combinational path from out_ready to in_ready.
REQ-021 Instruction is decoded combinationally at push; the stored entry holds {control, instr, pc, illegal}; decode is not repeated at the head.
REQ-022 Latency: push in cycle N makes the entry visible at the head (out_valid=1) in cycle N+1 when queue was empty; no same-cycle bypass.
REQ-023 out_valid = (count != 0); head outputs SHALL be stable while out_valid && !out_ready.
REQ-024 Simultaneous push and pop: count unchanged, write and read pointers both advance; legal when full only if in_ready was already 1 (i.e. not full).
REQ-025 Pointers wrap modulo DEPTH; count distinguishes full from empty.
REQ-026 Illegal entry: out_control = all zeros, out_illegal = 1; entry still occupies a slot and is popped normally.
REQ-027 Bubble encoding BUBBLE_INSTR (32'h0000_1111) decodes to all-zero control with out_illegal = 0.
REQ-028 illegal_count increments by 1 per pushed illegal instruction, saturating at all-ones.
REQ-029 flush: next cycle count = 0, both pointers = 0, out_valid = 0; a push in the flush cycle is dropped (in_ready=0); illegal_count is not cleared.
REQ-030 When out_valid = 0, out_control, out_instr, out_pc, out_illegal SHALL read zero.

Reset
REQ-031 reset_n low asynchronously sets count, pointers, illegal_count to 0; out_valid = 0; all head outputs 0; in_ready = 1 after release.
REQ-032 Reset asserted mid-operation discards all entries with no pop reported.

Configuration
REQ-033 Macro RV32M_EN: when defined, opcode 0110011 with funct7 = 0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to ALU_MUL..ALU_REMU, reg_write = 1, R_TYPE.
REQ-034 Without RV32M_EN, funct7 = 0000001 on opcode 0110011 SHALL be illegal (out_illegal = 1, illegal_count increments).

Structure
REQ-035 Package common gains ALU_MUL..ALU_REMU alu_op values, BUBBLE_INSTR constant, and decode_entry_type struct {control_type, instruction_type, illegal}; PC kept outside the struct as it is parametrised.
REQ-036 One combinational sub-module rv_decoder (instruction_type in; control_type and decode_failed out) instantiated once at the push side; storage, pointers and counters live in decode_queue.

Verification
REQ-037 Push ADDI x1,x0,5 (32'h0050_0093) into empty queue -> cycle+1 out_valid=1, alu_op=ALU_ADD, alu_src=1, reg_write=1, out_illegal=0.
REQ-038 Hold out_ready=0, push DEPTH instructions -> count=DEPTH, in_ready=0; next in_valid ignored; drain yields entries in push order with matching out_pc.
REQ-039 Push 32'hFFFF_FFFF three times -> out_illegal=1 each, illegal_count=3; preload counter near max -> saturates at all-ones.
REQ-040 Queue at count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, dropped instruction never appears.
REQ-041 Push MUL x3,x1,x2 (32'h0220_81B3) -> with RV32M_EN alu_op=ALU_MUL, out_illegal=0; without it out_illegal=1.
REQ-042 Continuous push/pop at count=1 for 2*DEPTH cycles -> count stays 1, pointers wrap, output order preserved; assert reset_n low mid-run -> count=0, out_valid=0 immediately.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: decoded control word, queue entry and ALU operations.
// ALU_MUL..ALU_REMU are only produced when the decoder is built with RV32M_EN.
package decode_queue_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef logic [INSTR_WIDTH-1:0] instruction_type;

    localparam instruction_type BUBBLE_INSTR = 32'h0000_1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU_MUL..ALU_REMU follow funct3 order so the decoder can index them directly.
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_type;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } instr_format_type;

    typedef struct packed {
        alu_op_type       alu_op;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             jump;
        instr_format_type fmt;
    } control_type;

    typedef struct packed {
        control_type     control;
        instruction_type instr;
        logic            illegal;
    } decode_entry_type;

    function automatic alu_op_type alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_queue_rv_decoder.sv
// Combinational RV32I decoder; RV32M_EN adds the multiply/divide group.
// Any unrecognised encoding yields an all-zero control word with decode_failed set.
module rv_decoder
    import decode_queue_pkg::*;
(
    input  instruction_type instr,
    output control_type     control,
    output logic            decode_failed
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    control_type ctrl;
    logic        bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ctrl = '0;
        bad  = 1'b0;
        if (instr != BUBBLE_INSTR) begin
            case (opcode)
                OPC_OP: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.fmt       = R_TYPE;
                    if (funct7 == F7_BASE) begin
                        ctrl.alu_op = alu_op_from_funct3(funct3, 1'b0);
                    end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                        ctrl.alu_op = alu_op_from_funct3(funct3, 1'b1);
                    end else if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
                        ctrl.alu_op = alu_op_type'(ALU_MUL + {2'b00, funct3});
`else
                        bad = 1'b1;
`endif
                    end else begin
                        bad = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.fmt       = I_TYPE;
                    case (funct3)
                        3'b001: begin
                            if (funct7 == F7_BASE) ctrl.alu_op = ALU_SLL;
                            else                   bad = 1'b1;
                        end
                        3'b101: begin
                            if (funct7 == F7_BASE)     ctrl.alu_op = ALU_SRL;
                            else if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                            else                       bad = 1'b1;
                        end
                        default: ctrl.alu_op = alu_op_from_funct3(funct3, 1'b0);
                    endcase
                end
                OPC_LOAD: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.mem_read  = 1'b1;
                    ctrl.fmt       = I_TYPE;
                    bad = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                end
                OPC_STORE: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.fmt       = S_TYPE;
                    bad = !(funct3 inside {3'b000, 3'b001, 3'b010});
                end
                OPC_BRANCH: begin
                    ctrl.alu_op = ALU_SUB;
                    ctrl.branch = 1'b1;
                    ctrl.fmt    = B_TYPE;
                    bad = (funct3 == 3'b010) || (funct3 == 3'b011);
                end
                OPC_LUI, OPC_AUIPC: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.fmt       = U_TYPE;
                end
                OPC_JAL: begin
                    ctrl.jump      = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.fmt       = J_TYPE;
                end
                OPC_JALR: begin
                    ctrl.jump      = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.fmt       = I_TYPE;
                    bad = (funct3 != 3'b000);
                end
                default: bad = 1'b1;
            endcase
        end
        if (bad) ctrl = '0;
    end

    assign control       = ctrl;
    assign decode_failed = bad;

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between fetch and execute; decode happens once, at push.
// RV32M_EN (see rv_decoder) enables the multiply/divide decode.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int PC_WIDTH      = 32,
    parameter int ILL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  instruction_type            in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output control_type                out_control,
    output instruction_type            out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_illegal,
    output logic [ILL_CNT_WIDTH-1:0]   illegal_count,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_type;

    decode_entry_type      entry_mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
    ptr_type               wr_ptr;
    ptr_type               rd_ptr;
    control_type           dec_control;
    logic                  dec_failed;
    decode_entry_type      head;
    logic                  push;
    logic                  pop;

    rv_decoder u_decoder (
        .instr         (in_instr),
        .control       (dec_control),
        .decode_failed (dec_failed)
    );

    // in_ready depends only on registered occupancy and flush, never on out_ready.
    assign in_ready  = (count < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: the slot storage is not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr] <= '{control: dec_control, instr: in_instr, illegal: dec_failed};
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_type'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_type'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Survives flush: it counts what fetch delivered, not what execute consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_count <= '0;
        end else if (push && dec_failed && (illegal_count != '1)) begin
            illegal_count <= illegal_count + ILL_CNT_WIDTH'(1);
        end
    end

    assign head        = entry_mem[rd_ptr];
    assign out_control = out_valid ? head.control : '0;
    assign out_instr   = out_valid ? head.instr   : '0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
    assign out_pc      = out_valid ? pc_mem[rd_ptr] : '0;

endmodule
